// File: rtl/mem_arb_pkg.sv
// Shared types for the cache/memory scheduler: bus encodings, tag ownership and grant selection.
package mem_arb_pkg;
   localparam int XLEN      = 32;
   localparam int MEM_TAG_W = 4;

   typedef enum logic [1:0] {BUS_NONE, BUS_LOAD, BUS_STORE} BUS_COMMAND;
   typedef enum logic [1:0] {BYTE, HALF, WORD, DOUBLE} MEM_SIZE;

   typedef enum logic {OWNER_I, OWNER_D} MEM_OWNER;

   typedef struct packed {
      logic     valid;
      MEM_OWNER owner;
   } tag_entry_t;

   typedef enum logic [1:0] {GRANT_NONE, GRANT_I, GRANT_D} grant_e;
endpackage

// File: rtl/mem_tag_table.sv
// Per-tag ownership table: a return clears its entry before a same-cycle accept sets it,
// so a recycled tag ends owned by the new requester. Tracks occupancy and a sticky error.
module mem_tag_table
   import mem_arb_pkg::*;
#(
   parameter int NUM_TAGS = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 alloc_vld_i,
   input  logic [MEM_TAG_W-1:0] alloc_tag_i,
   input  MEM_OWNER             alloc_owner_i,
   input  logic                 free_vld_i,
   input  logic [MEM_TAG_W-1:0] free_tag_i,
   output logic                 lookup_valid_o,
   output MEM_OWNER             lookup_owner_o,
   output logic [4:0]           outstanding_cnt_o,
   output logic                 tag_error_o
);
   tag_entry_t tbl_q [NUM_TAGS];
   tag_entry_t tbl_d [NUM_TAGS];
   logic [4:0] cnt_q, cnt_d;
   logic       err_q, err_d;
   logic       hit;

   assign lookup_valid_o    = tbl_q[free_tag_i].valid;
   assign lookup_owner_o    = tbl_q[free_tag_i].owner;
   assign hit               = free_vld_i && tbl_q[free_tag_i].valid;
   assign outstanding_cnt_o = cnt_q;
   assign tag_error_o       = err_q;

   always_comb begin
      tbl_d = tbl_q;
      err_d = err_q;
      if (free_vld_i) begin
         if (hit) tbl_d[free_tag_i].valid = 1'b0;
         else     err_d = 1'b1;
      end
      // Checked after the clear so a same-cycle recycle is not a duplicate.
      if (alloc_vld_i) begin
         if (tbl_d[alloc_tag_i].valid) err_d = 1'b1;
         tbl_d[alloc_tag_i] = '{valid: 1'b1, owner: alloc_owner_i};
      end
      cnt_d = cnt_q + {4'b0, alloc_vld_i} - {4'b0, hit};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_TAGS; i++) tbl_q[i] <= '{valid: 1'b0, owner: OWNER_I};
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         tbl_q <= tbl_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
endmodule

// File: rtl/mem_req_scheduler.sv
// Shares the memory port between Icache and Dcache (Dcache priority) and routes returns to the tag owner.
// Optional macro MEM_ARB_FAIRNESS_EN adds an Icache anti-starvation guard.
module mem_req_scheduler
   import mem_arb_pkg::*;
#(
   parameter int NUM_TAGS     = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  BUS_COMMAND           Dcache2mem_command,
   input  MEM_SIZE              Dcache2mem_size,
   input  logic [XLEN-1:0]      Dcache2mem_addr,
   input  logic [63:0]          Dcache2mem_data,
   input  BUS_COMMAND           Icache2mem_command,
   input  logic [XLEN-1:0]      Icache2mem_addr,
   input  logic [MEM_TAG_W-1:0] mem2cache_response,
   input  logic [63:0]          mem2cache_data,
   input  logic [MEM_TAG_W-1:0] mem2cache_tag,
   output BUS_COMMAND           cache2mem_command,
   output MEM_SIZE              cache2mem_size,
   output logic [XLEN-1:0]      cache2mem_addr,
   output logic [63:0]          cache2mem_data,
   output logic [MEM_TAG_W-1:0] mem2Dcache_response,
   output logic [MEM_TAG_W-1:0] mem2Icache_response,
   output logic [63:0]          mem2Dcache_data,
   output logic [63:0]          mem2Icache_data,
   output logic [MEM_TAG_W-1:0] mem2Dcache_tag,
   output logic [MEM_TAG_W-1:0] mem2Icache_tag,
   output logic [4:0]           outstanding_cnt,
   output logic                 tag_error
);
   grant_e   grant;
   logic     d_req, i_req, i_force, accept, alloc_vld, free_vld, lookup_valid;
   MEM_OWNER lookup_owner;

   // Masking requests under reset keeps every combinational output idle.
   assign d_req = !reset && (Dcache2mem_command != BUS_NONE);
   assign i_req = !reset && (Icache2mem_command != BUS_NONE);

`ifdef MEM_ARB_FAIRNESS_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic [SW-1:0] starve_cnt_q, starve_cnt_d;

   assign i_force = (starve_cnt_q == SW'(STARVE_LIMIT));

   always_comb begin
      starve_cnt_d = '0;
      if (i_req && (grant != GRANT_I))
         starve_cnt_d = i_force ? starve_cnt_q : starve_cnt_q + SW'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) starve_cnt_q <= '0;
      else       starve_cnt_q <= starve_cnt_d;
   end
`else
   // Strict Dcache priority; the limit only matters when the guard is built in.
   assign i_force = 1'b0 & (STARVE_LIMIT > 0);
`endif

   always_comb begin
      grant = GRANT_NONE;
      if (d_req && i_req) grant = i_force ? GRANT_I : GRANT_D;
      else if (d_req)     grant = GRANT_D;
      else if (i_req)     grant = GRANT_I;
   end

   always_comb begin
      cache2mem_command = BUS_NONE;
      cache2mem_size    = BYTE;
      cache2mem_addr    = '0;
      cache2mem_data    = '0;
      case (grant)
         GRANT_D: begin
            cache2mem_command = Dcache2mem_command;
            cache2mem_size    = Dcache2mem_size;
            cache2mem_addr    = Dcache2mem_addr;
            cache2mem_data    = Dcache2mem_data;
         end
         GRANT_I: begin
            cache2mem_command = Icache2mem_command;
            cache2mem_size    = DOUBLE;
            cache2mem_addr    = Icache2mem_addr;
         end
         default: ;
      endcase
   end

   assign accept              = (grant != GRANT_NONE) && (mem2cache_response != '0);
   assign alloc_vld           = accept && (cache2mem_command == BUS_LOAD);
   assign mem2Dcache_response = (grant == GRANT_D) ? mem2cache_response : '0;
   assign mem2Icache_response = (grant == GRANT_I) ? mem2cache_response : '0;

   assign free_vld        = !reset && (mem2cache_tag != '0);
   assign mem2Dcache_tag  = (free_vld && lookup_valid && lookup_owner == OWNER_D) ? mem2cache_tag : '0;
   assign mem2Icache_tag  = (free_vld && lookup_valid && lookup_owner == OWNER_I) ? mem2cache_tag : '0;
   assign mem2Dcache_data = mem2cache_data;
   assign mem2Icache_data = mem2cache_data;

   mem_tag_table #(.NUM_TAGS(NUM_TAGS)) u_tag_table (
      .clk_i             (clock),
      .rst_i             (reset),
      .alloc_vld_i       (alloc_vld),
      .alloc_tag_i       (mem2cache_response),
      .alloc_owner_i     ((grant == GRANT_D) ? OWNER_D : OWNER_I),
      .free_vld_i        (free_vld),
      .free_tag_i        (mem2cache_tag),
      .lookup_valid_o    (lookup_valid),
      .lookup_owner_o    (lookup_owner),
      .outstanding_cnt_o (outstanding_cnt),
      .tag_error_o       (tag_error)
   );
endmodule

// File: tb/tb_mem_req_scheduler.sv
// Bench for mem_req_scheduler: scoreboard of accepted tags and their owners, checked on returns.
module tb_mem_req_scheduler;
   import mem_arb_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   BUS_COMMAND  Dcache2mem_command, Icache2mem_command, cache2mem_command;
   MEM_SIZE     Dcache2mem_size, cache2mem_size;
   logic [31:0] Dcache2mem_addr, Icache2mem_addr, cache2mem_addr;
   logic [63:0] Dcache2mem_data, mem2cache_data, cache2mem_data;
   logic [63:0] mem2Dcache_data, mem2Icache_data;
   logic [3:0]  mem2cache_response, mem2cache_tag;
   logic [3:0]  mem2Dcache_response, mem2Icache_response, mem2Dcache_tag, mem2Icache_tag;
   logic [4:0]  outstanding_cnt;
   logic        tag_error;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] tag;
      MEM_OWNER   owner;
   } exp_t;
   exp_t sb[$];

   always #5 clock = ~clock;

   mem_req_scheduler #(.NUM_TAGS(16), .STARVE_LIMIT(4)) dut (
      .clock(clock), .reset(reset),
      .Dcache2mem_command(Dcache2mem_command), .Dcache2mem_size(Dcache2mem_size),
      .Dcache2mem_addr(Dcache2mem_addr), .Dcache2mem_data(Dcache2mem_data),
      .Icache2mem_command(Icache2mem_command), .Icache2mem_addr(Icache2mem_addr),
      .mem2cache_response(mem2cache_response), .mem2cache_data(mem2cache_data),
      .mem2cache_tag(mem2cache_tag),
      .cache2mem_command(cache2mem_command), .cache2mem_size(cache2mem_size),
      .cache2mem_addr(cache2mem_addr), .cache2mem_data(cache2mem_data),
      .mem2Dcache_response(mem2Dcache_response), .mem2Icache_response(mem2Icache_response),
      .mem2Dcache_data(mem2Dcache_data), .mem2Icache_data(mem2Icache_data),
      .mem2Dcache_tag(mem2Dcache_tag), .mem2Icache_tag(mem2Icache_tag),
      .outstanding_cnt(outstanding_cnt), .tag_error(tag_error)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      Dcache2mem_command = BUS_NONE;
      Dcache2mem_size    = BYTE;
      Dcache2mem_addr    = '0;
      Dcache2mem_data    = '0;
      Icache2mem_command = BUS_NONE;
      Icache2mem_addr    = '0;
      mem2cache_response = '0;
      mem2cache_tag      = '0;
      mem2cache_data     = '0;
   endtask

   task automatic sb_push(input logic [3:0] t, input MEM_OWNER o);
      exp_t e;
      e.tag   = t;
      e.owner = o;
      sb.push_back(e);
   endtask

   // Expected per-cache tag outputs for a return of tag t; unknown tags route nowhere.
   task automatic sb_take(input logic [3:0] t, output logic [3:0] ed, output logic [3:0] ei);
      ed = '0;
      ei = '0;
      for (int k = 0; k < sb.size(); k++) begin
         if (sb[k].tag == t) begin
            if (sb[k].owner == OWNER_D) ed = t;
            else                        ei = t;
            sb.delete(k);
            return;
         end
      end
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      Dcache2mem_command = BUS_LOAD;
      Dcache2mem_addr    = 32'h40;
      mem2cache_response = 4'd4;
      tick();
      tick();
      checks++;
      if (cache2mem_command !== BUS_NONE || mem2Dcache_response !== 4'd0) begin
         errors++;
         $display("FAIL reset_gate cmd=%0d resp=%0d want cmd=0 resp=0", cache2mem_command, mem2Dcache_response);
      end
      checks++;
      if (outstanding_cnt !== 5'd0 || tag_error !== 1'b0) begin
         errors++;
         $display("FAIL reset_state cnt=%0d err=%0b want 0/0", outstanding_cnt, tag_error);
      end
      reset = 1'b0;
      idle();
      sb.delete();
      tick();
   endtask

   task automatic test_dcache_load();
      logic [3:0] ed, ei;
      Dcache2mem_command = BUS_LOAD;
      Dcache2mem_size    = WORD;
      Dcache2mem_addr    = 32'h100;
      mem2cache_response = 4'd3;
      #1;
      checks++;
      if (cache2mem_command !== BUS_LOAD || cache2mem_addr !== 32'h100 ||
          mem2Dcache_response !== 4'd3 || mem2Icache_response !== 4'd0) begin
         errors++;
         $display("FAIL dload_accept cmd=%0d addr=%h dresp=%0d iresp=%0d want 1/100/3/0",
                  cache2mem_command, cache2mem_addr, mem2Dcache_response, mem2Icache_response);
      end
      sb_push(4'd3, OWNER_D);
      tick();
      idle();
      checks++;
      if (outstanding_cnt !== 5'd1) begin
         errors++;
         $display("FAIL dload_cnt1 got %0d want 1", outstanding_cnt);
      end
      tick();
      mem2cache_tag  = 4'd3;
      mem2cache_data = 64'hDEAD_BEEF_0123_4567;
      #1;
      sb_take(4'd3, ed, ei);
      checks++;
      if (mem2Dcache_tag !== ed || mem2Icache_tag !== ei || mem2Dcache_data !== 64'hDEAD_BEEF_0123_4567) begin
         errors++;
         $display("FAIL dload_return dtag=%0d itag=%0d data=%h want %0d/%0d/deadbeef01234567",
                  mem2Dcache_tag, mem2Icache_tag, mem2Dcache_data, ed, ei);
      end
      tick();
      idle();
      checks++;
      if (outstanding_cnt !== 5'd0 || tag_error !== 1'b0) begin
         errors++;
         $display("FAIL dload_cnt0 cnt=%0d err=%0b want 0/0", outstanding_cnt, tag_error);
      end
   endtask

   task automatic test_starvation();
      logic [31:0] exp_addr;
      Dcache2mem_command = BUS_LOAD;
      Dcache2mem_size    = WORD;
      Dcache2mem_addr    = 32'hD00;
      Dcache2mem_data    = 64'h1111;
      Icache2mem_command = BUS_LOAD;
      Icache2mem_addr    = 32'h1100;
      for (int c = 0; c < 12; c++) begin
         #1;
`ifdef MEM_ARB_FAIRNESS_EN
         exp_addr = (c % 5 == 4) ? 32'h1100 : 32'hD00;
`else
         exp_addr = 32'hD00;
`endif
         checks++;
         if (cache2mem_addr !== exp_addr) begin
            errors++;
            $display("FAIL starve_grant cycle=%0d addr=%h want %h", c, cache2mem_addr, exp_addr);
         end
         if (exp_addr == 32'h1100) begin
            checks++;
            if (cache2mem_size !== DOUBLE || cache2mem_data !== 64'd0) begin
               errors++;
               $display("FAIL starve_iforce size=%0d data=%h want 3/0", cache2mem_size, cache2mem_data);
            end
         end
         tick();
      end
      idle();
      checks++;
      if (outstanding_cnt !== 5'd0) begin
         errors++;
         $display("FAIL starve_cnt got %0d want 0", outstanding_cnt);
      end
      tick();
   endtask

   task automatic test_out_of_order();
      logic [3:0] ed, ei;
      Icache2mem_command = BUS_LOAD;
      Icache2mem_addr    = 32'h2000;
      mem2cache_response = 4'd5;
      #1;
      checks++;
      if (mem2Icache_response !== 4'd5 || mem2Dcache_response !== 4'd0 || cache2mem_size !== DOUBLE) begin
         errors++;
         $display("FAIL ooo_iaccept iresp=%0d dresp=%0d size=%0d want 5/0/3",
                  mem2Icache_response, mem2Dcache_response, cache2mem_size);
      end
      sb_push(4'd5, OWNER_I);
      tick();
      idle();
      Dcache2mem_command = BUS_LOAD;
      Dcache2mem_addr    = 32'h3000;
      mem2cache_response = 4'd6;
      #1;
      sb_push(4'd6, OWNER_D);
      tick();
      idle();
      checks++;
      if (outstanding_cnt !== 5'd2) begin
         errors++;
         $display("FAIL ooo_cnt2 got %0d want 2", outstanding_cnt);
      end
      for (int r = 0; r < 2; r++) begin
         mem2cache_tag = (r == 0) ? 4'd6 : 4'd5;
         #1;
         sb_take(mem2cache_tag, ed, ei);
         checks++;
         if (mem2Dcache_tag !== ed || mem2Icache_tag !== ei) begin
            errors++;
            $display("FAIL ooo_return tag=%0d dtag=%0d itag=%0d want %0d/%0d",
                     mem2cache_tag, mem2Dcache_tag, mem2Icache_tag, ed, ei);
         end
         tick();
         mem2cache_tag = '0;
      end
      checks++;
      if (outstanding_cnt !== 5'd0 || tag_error !== 1'b0) begin
         errors++;
         $display("FAIL ooo_cnt0 cnt=%0d err=%0b want 0/0", outstanding_cnt, tag_error);
      end
   endtask

   task automatic test_store();
      logic [3:0] ed, ei;
      Dcache2mem_command = BUS_STORE;
      Dcache2mem_addr    = 32'h400;
      Dcache2mem_data    = 64'hCAFE;
      mem2cache_response = 4'd2;
      #1;
      checks++;
      if (mem2Dcache_response !== 4'd2 || cache2mem_data !== 64'hCAFE) begin
         errors++;
         $display("FAIL store_accept dresp=%0d data=%h want 2/cafe", mem2Dcache_response, cache2mem_data);
      end
      tick();
      idle();
      checks++;
      if (outstanding_cnt !== 5'd0) begin
         errors++;
         $display("FAIL store_cnt got %0d want 0", outstanding_cnt);
      end
      mem2cache_tag = 4'd2;
      #1;
      sb_take(4'd2, ed, ei);
      checks++;
      if (mem2Dcache_tag !== ed || mem2Icache_tag !== ei) begin
         errors++;
         $display("FAIL store_return dtag=%0d itag=%0d want %0d/%0d", mem2Dcache_tag, mem2Icache_tag, ed, ei);
      end
      tick();
      idle();
      tick();
      tick();
      checks++;
      if (tag_error !== 1'b1) begin
         errors++;
         $display("FAIL store_err_sticky got %0b want 1", tag_error);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sb.delete();
      checks++;
      if (tag_error !== 1'b0) begin
         errors++;
         $display("FAIL store_err_clear got %0b want 0", tag_error);
      end
   endtask

   task automatic test_same_cycle();
      logic [3:0] ed, ei;
      Icache2mem_command = BUS_LOAD;
      Icache2mem_addr    = 32'h5000;
      mem2cache_response = 4'd7;
      #1;
      sb_push(4'd7, OWNER_I);
      tick();
      idle();
      Dcache2mem_command = BUS_LOAD;
      Dcache2mem_addr    = 32'h6000;
      mem2cache_response = 4'd7;
      mem2cache_tag      = 4'd7;
      #1;
      sb_take(4'd7, ed, ei);
      checks++;
      if (mem2Icache_tag !== ei || mem2Dcache_tag !== ed || mem2Dcache_response !== 4'd7) begin
         errors++;
         $display("FAIL same_cycle dtag=%0d itag=%0d dresp=%0d want %0d/%0d/7",
                  mem2Dcache_tag, mem2Icache_tag, mem2Dcache_response, ed, ei);
      end
      sb_push(4'd7, OWNER_D);
      tick();
      idle();
      checks++;
      if (outstanding_cnt !== 5'd1 || tag_error !== 1'b0) begin
         errors++;
         $display("FAIL same_cycle_cnt cnt=%0d err=%0b want 1/0", outstanding_cnt, tag_error);
      end
      mem2cache_tag = 4'd7;
      #1;
      sb_take(4'd7, ed, ei);
      checks++;
      if (mem2Dcache_tag !== ed || mem2Icache_tag !== ei) begin
         errors++;
         $display("FAIL same_cycle_owner dtag=%0d itag=%0d want %0d/%0d", mem2Dcache_tag, mem2Icache_tag, ed, ei);
      end
      tick();
      idle();
      checks++;
      if (outstanding_cnt !== 5'd0) begin
         errors++;
         $display("FAIL same_cycle_cnt0 got %0d want 0", outstanding_cnt);
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] ed, ei;
      for (int t = 1; t <= 3; t++) begin
         Dcache2mem_command = BUS_LOAD;
         Dcache2mem_addr    = 32'h7000 + 32'(t);
         mem2cache_response = 4'(t);
         #1;
         sb_push(4'(t), OWNER_D);
         tick();
      end
      idle();
      checks++;
      if (outstanding_cnt !== 5'd3) begin
         errors++;
         $display("FAIL midreset_cnt3 got %0d want 3", outstanding_cnt);
      end
      reset = 1'b1;
      Dcache2mem_command = BUS_LOAD;
      Dcache2mem_addr    = 32'h8000;
      mem2cache_response = 4'd9;
      #1;
      checks++;
      if (cache2mem_command !== BUS_NONE || cache2mem_addr !== 32'd0 || mem2Dcache_response !== 4'd0) begin
         errors++;
         $display("FAIL midreset_cmd cmd=%0d addr=%h resp=%0d want 0/0/0",
                  cache2mem_command, cache2mem_addr, mem2Dcache_response);
      end
      tick();
      reset = 1'b0;
      idle();
      sb.delete();
      checks++;
      if (outstanding_cnt !== 5'd0) begin
         errors++;
         $display("FAIL midreset_cnt0 got %0d want 0", outstanding_cnt);
      end
      for (int t = 1; t <= 3; t++) begin
         mem2cache_tag = 4'(t);
         #1;
         sb_take(mem2cache_tag, ed, ei);
         checks++;
         if (mem2Dcache_tag !== ed || mem2Icache_tag !== ei) begin
            errors++;
            $display("FAIL midreset_return tag=%0d dtag=%0d itag=%0d want %0d/%0d",
                     t, mem2Dcache_tag, mem2Icache_tag, ed, ei);
         end
         tick();
      end
      idle();
      checks++;
      if (tag_error !== 1'b1 || outstanding_cnt !== 5'd0) begin
         errors++;
         $display("FAIL midreset_err err=%0b cnt=%0d want 1/0", tag_error, outstanding_cnt);
      end
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_dcache_load();
      test_starvation();
      test_out_of_order();
      test_store();
      test_same_cycle();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_req_scheduler.md
# mem_req_scheduler

Stateful scheduler that shares the single main-memory port between the Icache and the Dcache. It picks one requester per cycle using Dcache priority with an Icache anti-starvation guard. It records which requester owns each accepted memory tag and routes returned data only to that owner. It sits between both caches and `mem`, and replaces stateless priority muxing.

## Interface
Parameters:
- `NUM_TAGS`, 16: memory tag space. Tag 0 is reserved for "no tag"; usable tags are 1..15.
- `STARVE_LIMIT`, 4: consecutive cycles the Icache may be denied while requesting before it is force-granted.

Ports:
- `clock` in 1: system clock. Single clock domain.
- `reset` in 1: synchronous, active-high.
- `Dcache2mem_command` in BUS_COMMAND: Dcache request (BUS_NONE/BUS_LOAD/BUS_STORE).
- `Dcache2mem_size` in MEM_SIZE: Dcache access size.
- `Dcache2mem_addr` in `XLEN`: Dcache address.
- `Dcache2mem_data` in 64: Dcache store data.
- `Icache2mem_command` in BUS_COMMAND: Icache request (loads only).
- `Icache2mem_addr` in `XLEN`: Icache address.
- `mem2cache_response` in 4: accept tag from memory. 0 means rejected.
- `mem2cache_data` in 64: returned load data.
- `mem2cache_tag` in 4: tag of the returned data. 0 means no return.
- `cache2mem_command`, `cache2mem_size`, `cache2mem_addr`, `cache2mem_data` out: granted request driven to memory.
- `mem2Dcache_response`, `mem2Icache_response` out 4: accept tag, delivered to the granted requester only; 0 to the other.
- `mem2Dcache_data`, `mem2Icache_data` out 64: copy of `mem2cache_data`.
- `mem2Dcache_tag`, `mem2Icache_tag` out 4: returned tag, delivered to the owner only; 0 to the other.
- `outstanding_cnt` out 5: number of valid tag-table entries.
- `tag_error` out 1: sticky flag. Set when a returned tag has no valid owner.

## Operation
- **Grant selection:** combinational, from current requests and the registered starvation counter `starve_cnt`.
  - Neither requesting: grant none; drive BUS_NONE, addr 0, data 0.
  - Only one requesting: grant it.
  - Both requesting: grant the Icache if `starve_cnt == STARVE_LIMIT`, otherwise grant the Dcache.
- **Memory drive:** the granted request goes to memory.
  - An Icache grant forces size DOUBLE and data 0.
  - While `reset` is high, `cache2mem_command` is forced to BUS_NONE.
- **Starvation counter:** `starve_cnt` increments when the Icache requests and is not granted, saturating at STARVE_LIMIT. It clears whenever the Icache is granted or not requesting.
- **Accept handling:** accept = grant present and `mem2cache_response != 0`.
  - The response tag is returned only to the granted cache.
  - A requester holds its command until it sees a nonzero response.
- **Tag table:** `NUM_TAGS` entries of {valid, owner}.
  - A load accept with tag T sets entry T to {1, owner}.
  - Store accepts allocate nothing; memory returns no data for stores.
- **Data return:** when `mem2cache_tag = T != 0`:
  - If entry T is valid, drive T on the owner's tag output and clear the entry.
  - If entry T is invalid, drive 0 on both tag outputs and set `tag_error`.
- **Same-cycle return and accept of the same tag T:** the return is processed first (clear), then the accept (set). End state: valid with the new owner.
- **Duplicate accept on a still-valid tag:** overwrite the entry and set `tag_error`.
- **`outstanding_cnt`:** +1 per load accept, −1 per valid return, net change when both occur in the same cycle.

## Timing
- Grant, accept-tag routing and data routing are all combinational (0-cycle). Memory samples the command in the same cycle.
- Table update, `starve_cnt`, `outstanding_cnt` and `tag_error` update on the rising `clock` edge.
- A return can be routed no earlier than the cycle after its accept.
- Reset values:
  - Table all invalid; `starve_cnt` = 0; `outstanding_cnt` = 0; `tag_error` = 0.
  - Combinational outputs are BUS_NONE/0 during reset.
- Reset mid-operation: all outstanding ownership is discarded. Returns arriving after reset raise `tag_error`.

## Configuration
- `MEM_ARB_FAIRNESS_EN`
  - Defined: starvation guard active as described above.
  - Undefined: strict Dcache priority. The `starve_cnt` logic is removed and the Icache is granted only when the Dcache is idle.

## Structure
- Package `mem_arb_pkg`:
  - `typedef enum logic {OWNER_I, OWNER_D} MEM_OWNER`.
  - `tag_entry_t` struct {valid, owner}.
  - `localparam MEM_TAG_W = 4`.
- BUS_COMMAND and MEM_SIZE come from the existing shared header.
- One sub-module: `mem_tag_table`. It holds entry storage, clear-before-set update, occupancy count and error detection. It takes alloc/free tag, owner and valid strobes, and returns the lookup owner and valid bit.

## Test plan
1. Dcache LOAD only, memory responds 3; return tag 3 two cycles later → `mem2Dcache_response` = 3, `mem2Icache_response` = 0; later `mem2Dcache_tag` = 3, `mem2Icache_tag` = 0; `outstanding_cnt` goes 1→0.
2. Both request loads continuously, STARVE_LIMIT = 4, fairness enabled → Dcache granted for 4 cycles, Icache granted on the 5th, then `starve_cnt` returns to 0. With the macro undefined, the Icache is never granted.
3. Icache accepted with tag 5 and Dcache accepted with tag 6; returns arrive 6 then 5 → out-of-order routing: tag 6 goes to the Dcache, tag 5 to the Icache.
4. Dcache STORE accepted with tag 2 → no table entry is made and `outstanding_cnt` stays 0. A later return of tag 2 sets `tag_error` = 1, held until reset.
5. Same cycle: return of tag 7 (owner I) and a new Dcache load accept with tag 7 → Icache receives tag 7; entry 7 = {1, D}; `outstanding_cnt` is unchanged.
6. Assert `reset` with 3 loads outstanding → the next cycle shows `outstanding_cnt` = 0, command BUS_NONE during reset, and all entries invalid.
